fp_result_collector: RTL and testbench

// - Issue/return end of the fixed-latency FP multiplier pipeline. Accepts tagged operations

---
 rtl/fp_result_collector.sv | 178 +++++++++++++++++
 tb/tb_fp_result_collector.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_collector.sv
// Issue credits, in-flight tracker and result FIFO for the fixed-latency FP multiplier.
// Optional macro FP_RESULT_BYPASS_EN presents a returning result combinationally when the FIFO is empty.
`ifndef FP_MULT_LATENCY
`define FP_MULT_LATENCY 4
`endif

module fp_result_collector_chk #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             push,
    input logic [CNT_W-1:0] count
);
    // Credits must make a push into a full buffer impossible.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CNT_W'(FIFO_DEPTH))));
endmodule

module fp_result_collector #(
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_WIDTH    = 6,
    parameter int PIPE_LATENCY = `FP_MULT_LATENCY,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [TAG_WIDTH-1:0]  issue_tag,
    output logic                  issue_ready,
    output logic                  pipe_enable,
    input  logic [DATA_WIDTH-1:0] pipe_res,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [TAG_WIDTH-1:0]  wb_tag
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + PIPE_LATENCY + 1);
    localparam int ENT_W = DATA_WIDTH + TAG_WIDTH;

    logic [PIPE_LATENCY-1:0] trk_valid_r;
    logic [TAG_WIDTH-1:0]    trk_tag_r [PIPE_LATENCY];
    logic [ENT_W-1:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [CNT_W-1:0]        count_r;

    logic                 issue_fire_s;
    logic                 ret_valid_s;
    logic [TAG_WIDTH-1:0] ret_tag_s;
    logic                 fifo_nonempty_s;
    logic                 bypass_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 wb_fire_s;
    logic                 busy_s;
    logic [OCC_W-1:0]     occ_s;

    assign ret_valid_s     = trk_valid_r[PIPE_LATENCY-1];
    assign ret_tag_s       = trk_tag_r[PIPE_LATENCY-1];
    assign fifo_nonempty_s = (count_r != {CNT_W{1'b0}});

`ifdef FP_RESULT_BYPASS_EN
    assign bypass_s = ret_valid_s & ~fifo_nonempty_s;
`else
    assign bypass_s = 1'b0;
`endif

    assign wb_valid     = fifo_nonempty_s | bypass_s;
    assign wb_fire_s    = wb_valid & wb_ready;
    assign pop_s        = fifo_nonempty_s & wb_ready;
    assign push_s       = ret_valid_s & ~(bypass_s & wb_ready);
    assign issue_ready  = (occ_s < OCC_W'(FIFO_DEPTH)) |
                          (wb_fire_s & (occ_s == OCC_W'(FIFO_DEPTH)));
    assign issue_fire_s = issue_valid & issue_ready;
    assign pipe_enable  = issue_fire_s | busy_s;

    // Occupancy (buffered + in flight) and whether the multiplier still needs to advance;
    // the returning stage already has its result on pipe_res, so it does not keep the pipe busy.
    always_comb begin
        occ_s  = OCC_W'(count_r);
        busy_s = 1'b0;
        for (int i = 0; i < PIPE_LATENCY; i++) begin
            occ_s = occ_s + OCC_W'(trk_valid_r[i]);
            if (i < PIPE_LATENCY - 1) begin
                busy_s = busy_s | trk_valid_r[i];
            end else begin
                busy_s = busy_s;
            end
        end
    end

    // Writeback head selection.
    always_comb begin
        wb_data = {DATA_WIDTH{1'b0}};
        wb_tag  = {TAG_WIDTH{1'b0}};
`ifdef FP_RESULT_BYPASS_EN
        if (bypass_s) begin
            wb_data = pipe_res;
            wb_tag  = ret_tag_s;
        end else if (fifo_nonempty_s) begin
            {wb_data, wb_tag} = mem_r[rd_ptr_r];
        end else begin
            wb_data = {DATA_WIDTH{1'b0}};
            wb_tag  = {TAG_WIDTH{1'b0}};
        end
`else
        if (fifo_nonempty_s) begin
            {wb_data, wb_tag} = mem_r[rd_ptr_r];
        end else begin
            wb_data = {DATA_WIDTH{1'b0}};
            wb_tag  = {TAG_WIDTH{1'b0}};
        end
`endif
    end

    // In-flight tracker shifting in lockstep with the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_valid_r <= {PIPE_LATENCY{1'b0}};
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                trk_tag_r[i] <= {TAG_WIDTH{1'b0}};
            end
        end else begin
            trk_valid_r[0] <= issue_fire_s;
            trk_tag_r[0]   <= issue_tag;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                trk_valid_r[i] <= trk_valid_r[i-1];
                trk_tag_r[i]   <= trk_tag_r[i-1];
            end
        end
    end

    // Result storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {ENT_W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {pipe_res, ret_tag_s};
        end
    end

    // FIFO pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    fp_result_collector_chk #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W     (CNT_W)
    ) u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .count(count_r)
    );
endmodule

// File: tb/tb_fp_result_collector.sv
// Scoreboard bench for fp_result_collector with a behavioural latency-L multiplier on pipe_res.
`timescale 1ns/1ps
module tb_fp_result_collector;
    localparam int DW    = 32;
    localparam int TW    = 6;
    localparam int L     = 4;
    localparam int DEPTH = 8;
`ifdef FP_RESULT_BYPASS_EN
    localparam int LAT = L;
`else
    localparam int LAT = L + 1;
`endif

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue_valid = 1'b0;
    logic [TW-1:0] issue_tag = '0;
    logic          wb_ready = 1'b0;
    logic [15:0]   op_a = '0;
    logic [15:0]   op_b = '0;
    logic          issue_ready, pipe_enable, wb_valid;
    logic [DW-1:0] pipe_res, wb_data;
    logic [TW-1:0] wb_tag;
    logic [DW-1:0] mul_stage [L];

    int   vectors = 0;
    int   miscompares = 0;
    int   cycle = 0;
    int   fires = 0;
    exp_t sb_q[$];
    int   deliv_cyc[$];
    exp_t e;
    logic hold_pend = 1'b0;
    logic [DW-1:0] hold_data;
    logic [TW-1:0] hold_tag;

    always #5 clk = ~clk;

    fp_result_collector #(
        .DATA_WIDTH  (DW),
        .TAG_WIDTH   (TW),
        .PIPE_LATENCY(L),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_tag  (issue_tag),
        .issue_ready(issue_ready),
        .pipe_enable(pipe_enable),
        .pipe_res   (pipe_res),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_tag     (wb_tag)
    );

    // Multiplier: samples operands when enabled, result reaches pipe_res after L enabled cycles.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (rst) begin
            for (int i = 0; i < L; i++) mul_stage[i] <= '0;
        end else if (pipe_enable) begin
            mul_stage[0] <= {16'h0000, op_a} * {16'h0000, op_b};
            for (int i = 1; i < L; i++) mul_stage[i] <= mul_stage[i-1];
        end
    end
    assign pipe_res = mul_stage[L-1];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_op(input logic [TW-1:0] tag);
        issue_valid = 1'b1;
        issue_tag   = tag;
        op_a        = 16'($urandom);
        op_b        = 16'($urandom);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        wb_ready = 1'b1;
        while ((sb_q.size() != 0 || wb_valid) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(n < budget), 64'd1);
    endtask

    // Monitor: records issued operations and checks every writeback transfer in order.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check("hold_valid", 64'(wb_valid), 64'd1);
                    check("hold_data", 64'(wb_data), 64'(hold_data));
                    check("hold_tag", 64'(wb_tag), 64'(hold_tag));
                end
                if (issue_valid && issue_ready) begin
                    sb_q.push_back({issue_tag, {16'h0000, op_a} * {16'h0000, op_b}});
                    fires++;
                end
                if (wb_valid && wb_ready) begin
                    if (sb_q.size() == 0) begin
                        check("stale_result", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("wb_tag", 64'(wb_tag), 64'(e.tag));
                        check("wb_data", 64'(wb_data), 64'(e.data));
                    end
                    deliv_cyc.push_back(cycle);
                end
                hold_pend = wb_valid && !wb_ready;
                hold_data = wb_data;
                hold_tag  = wb_tag;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int t0;
        int acc;
        int n;

        // Reset state
        repeat (3) step();
        sample();
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        check("rst_pipe_enable", 64'(pipe_enable), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_wb_tag", 64'(wb_tag), 64'd0);
        step();
        rst = 1'b0;
        wb_ready = 1'b1;
        step();

        // Single op, tag 0x05
        step();
        drive_op(6'h05);
        t0 = cycle;
        for (int k = 0; k <= L + 3; k++) begin
            if (k > 0) begin
                step();
                issue_valid = 1'b0;
            end
            sample();
            check("single_pipe_enable", 64'(pipe_enable), 64'(k < L));
            check("single_wb_valid", 64'(wb_valid), 64'(k == LAT));
            if (k == LAT) check("single_wb_tag", 64'(wb_tag), 64'h05);
        end
        wait_drain(50);

        // Back-to-back issues, tags 0..7
        deliv_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            step();
            drive_op(TW'(i));
            if (i == 0) t0 = cycle;
            sample();
            check("b2b_issue_ready", 64'(issue_ready), 64'd1);
        end
        step();
        issue_valid = 1'b0;
        wait_drain(100);
        check("b2b_count", 64'(deliv_cyc.size()), 64'd8);
        for (int i = 0; i < deliv_cyc.size(); i++)
            check("b2b_cycle", 64'(deliv_cyc[i]), 64'(t0 + LAT + i));

        // Backpressure: credits limit acceptance to DEPTH
        wb_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            step();
            drive_op(TW'($urandom));
            sample();
            if (issue_ready) acc++;
        end
        step();
        issue_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'(DEPTH));
        repeat (L + 2) step();
        sample();
        check("bp_ready_low", 64'(issue_ready), 64'd0);
        check("bp_wb_valid", 64'(wb_valid), 64'd1);
        deliv_cyc.delete();
        step();
        wb_ready = 1'b1;
        t0 = cycle;
        sample();
        check("bp_first_pop_ready", 64'(issue_ready), 64'd1);
        wait_drain(100);
        check("bp_drain_count", 64'(deliv_cyc.size()), 64'(DEPTH));
        for (int i = 0; i < deliv_cyc.size(); i++)
            check("bp_drain_cycle", 64'(deliv_cyc[i]), 64'(t0 + i));

        // Full buffer, single wb_ready pulse: pop and issue in the same cycle
        wb_ready = 1'b0;
        fires = 0;
        for (int i = 0; i < DEPTH + L + 2; i++) begin
            step();
            drive_op(TW'($urandom));
        end
        sample();
        check("full_fires", 64'(fires), 64'(DEPTH));
        check("full_ready_low", 64'(issue_ready), 64'd0);
        deliv_cyc.delete();
        step();
        drive_op(TW'($urandom));
        wb_ready = 1'b1;
        sample();
        check("full_pulse_ready", 64'(issue_ready), 64'd1);
        check("full_pulse_valid", 64'(wb_valid), 64'd1);
        for (int i = 0; i < L + 2; i++) begin
            step();
            wb_ready = 1'b0;
            drive_op(TW'($urandom));
        end
        sample();
        check("full_after_fires", 64'(fires), 64'(DEPTH + 1));
        check("full_after_ready", 64'(issue_ready), 64'd0);
        step();
        issue_valid = 1'b0;
        wait_drain(100);
        check("full_total_deliv", 64'(deliv_cyc.size()), 64'(DEPTH + 1));

        // Reset with results in flight and buffered
        wb_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            drive_op(TW'(6'h10 + i));
        end
        step();
        issue_valid = 1'b0;
        repeat (L + 1) step();
        for (int i = 0; i < 3; i++) begin
            step();
            drive_op(TW'(6'h20 + i));
        end
        step();
        issue_valid = 1'b0;
        rst = 1'b1;
        sample();
        check("pre_rst_wb_valid", 64'(wb_valid), 64'd1);
        step();
        rst = 1'b0;
        sb_q.delete();
        wb_ready = 1'b1;
        deliv_cyc.delete();
        sample();
        check("mid_rst_wb_valid", 64'(wb_valid), 64'd0);
        check("mid_rst_issue_ready", 64'(issue_ready), 64'd1);
        check("mid_rst_wb_tag", 64'(wb_tag), 64'd0);
        check("mid_rst_wb_data", 64'(wb_data), 64'd0);
        for (int k = 0; k < 2 * L; k++) begin
            step();
            sample();
            check("mid_rst_no_stale", 64'(wb_valid), 64'd0);
        end
        check("mid_rst_deliv", 64'(deliv_cyc.size()), 64'd0);

        // Random traffic
        fires = 0;
        n = 0;
        while (fires < 10000 && n < 60000) begin
            step();
            issue_valid = 1'($urandom_range(0, 1));
            issue_tag   = TW'($urandom);
            op_a        = 16'($urandom);
            op_b        = 16'($urandom);
            wb_ready    = 1'($urandom_range(0, 1));
            n++;
        end
        step();
        issue_valid = 1'b0;
        wait_drain(200);
        check("rand_ops_done", 64'(fires >= 10000), 64'd1);
        check("rand_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
